cache_ctrl: RTL

- Direct-mapped, write-back, write-allocate controller for the pipeline data cache.
- Sits between the MEM stage and the cache line storage array: 4 line blocks, each 4 words with a 26-bit tag and valid/dirty bits.
- Decides hit or miss, drives the selected line's write/tag/valid/dirty controls, and sequences line write-back and refill over a request/ack memory port.
- Stalls the pipeline for the whole miss.

---
 rtl/cache_ctrl_if.sv | 45 ++++
 rtl/cache_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_if.sv
// Bundle of pipeline, line-block and memory-port signals around the data cache controller.
// The slave modport is the controller's view; master is the surrounding environment.
interface cache_ctrl_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic [1:0]  LineIndex;
   logic [1:0]  BlkOffset;
   logic        BlkWE;
   logic        BlkSetValid;
   logic        BlkSetDirty;
   logic [25:0] BlkSetTag;
   logic [31:0] BlkWD;
   logic        BlkValid;
   logic        BlkDirty;
   logic [25:0] BlkTag;
   logic [31:0] BlkRD;
   logic        MemReq;
   logic        MemWE;
   logic [31:0] MemAddr;
   logic [31:0] MemWD;
   logic [31:0] MemRD;
   logic        MemAck;

   modport slave (
      input  MemRead, MemWrite, Addr, WriteData,
      output ReadData, Stall,
      output LineIndex, BlkOffset, BlkWE, BlkSetValid, BlkSetDirty, BlkSetTag, BlkWD,
      input  BlkValid, BlkDirty, BlkTag, BlkRD,
      output MemReq, MemWE, MemAddr, MemWD,
      input  MemRD, MemAck
   );

   modport master (
      output MemRead, MemWrite, Addr, WriteData,
      input  ReadData, Stall,
      input  LineIndex, BlkOffset, BlkWE, BlkSetValid, BlkSetDirty, BlkSetTag, BlkWD,
      output BlkValid, BlkDirty, BlkTag, BlkRD,
      input  MemReq, MemWE, MemAddr, MemWD,
      output MemRD, MemAck
   );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller: 4 lines of 4 words,
// hit detection in IDLE, then line write-back and refill over a request/ack memory port.
module cache_ctrl (
   input  logic        CLK,
   input  logic        Reset,
   cache_ctrl_if.slave bus
);
   localparam int TAG_W      = 26;
   localparam int INDEX_W    = 2;
   localparam int LINE_WORDS = 4;
   localparam int OFF_W      = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [OFF_W-1:0]   cnt_q, cnt_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [INDEX_W-1:0] idx_q, idx_d;

   logic               req_s;
   logic               hit_s;
   logic               last_s;
   logic [TAG_W-1:0]   addr_tag_s;

   assign addr_tag_s   = bus.Addr[31:6];
   // Reset suppresses the request so Stall and block writes fall with it, not a cycle later.
   assign req_s        = (bus.MemRead | bus.MemWrite) & ~Reset;
   assign hit_s        = bus.BlkValid & (bus.BlkTag == addr_tag_s);
   assign last_s       = (cnt_q == OFF_W'(LINE_WORDS - 1));
   assign bus.ReadData = bus.BlkRD;

   // State, word counter and latched miss tag/index
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= {OFF_W{1'b0}};
         tag_q   <= {TAG_W{1'b0}};
         idx_q   <= {INDEX_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and all block/memory controls
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      tag_d           = tag_q;
      idx_d           = idx_q;
      bus.Stall       = 1'b0;
      bus.LineIndex   = idx_q;
      bus.BlkOffset   = cnt_q;
      bus.BlkWE       = 1'b0;
      bus.BlkSetValid = 1'b0;
      bus.BlkSetDirty = 1'b0;
      bus.BlkSetTag   = tag_q;
      bus.BlkWD       = 32'd0;
      bus.MemReq      = 1'b0;
      bus.MemWE       = 1'b0;
      bus.MemAddr     = {tag_q, idx_q, cnt_q, 2'b00};
      bus.MemWD       = 32'd0;

      case (state_q)
         IDLE: begin
            bus.LineIndex = bus.Addr[5:4];
            bus.BlkOffset = bus.Addr[3:2];
            if (req_s && hit_s) begin
               if (bus.MemWrite) begin
                  bus.BlkWE       = 1'b1;
                  bus.BlkWD       = bus.WriteData;
                  bus.BlkSetValid = 1'b1;
                  bus.BlkSetDirty = 1'b1;
                  bus.BlkSetTag   = addr_tag_s;
               end else begin
                  bus.BlkWE       = 1'b0;
               end
            end else if (req_s) begin
               bus.Stall = 1'b1;
               tag_d     = addr_tag_s;
               idx_d     = bus.Addr[5:4];
               cnt_d     = {OFF_W{1'b0}};
               if (bus.BlkDirty) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = REFILL;
               end
            end else begin
               state_d = IDLE;
            end
         end

         WRITEBACK: begin
            // The victim's own tag addresses the write-back; the line is untouched until refill.
            bus.Stall   = 1'b1;
            bus.MemReq  = 1'b1;
            bus.MemWE   = 1'b1;
            bus.MemAddr = {bus.BlkTag, idx_q, cnt_q, 2'b00};
            bus.MemWD   = bus.BlkRD;
            if (bus.MemAck) begin
               cnt_d = cnt_q + 2'd1;
               if (last_s) begin
                  state_d = REFILL;
               end else begin
                  state_d = WRITEBACK;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         REFILL: begin
            bus.Stall  = 1'b1;
            bus.MemReq = 1'b1;
            bus.MemWE  = 1'b0;
            if (bus.MemAck) begin
               bus.BlkWE       = 1'b1;
               bus.BlkWD       = bus.MemRD;
               bus.BlkSetTag   = tag_q;
               bus.BlkSetDirty = 1'b0;
               bus.BlkSetValid = last_s;
               cnt_d           = cnt_q + 2'd1;
               if (last_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = REFILL;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule
